// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller: walks a PC through the instruction RAM read port and
// buffers returned words in a small prefetch FIFO presented over valid/ready.
module imem_fetch_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  input  logic                  stop,
  output logic [ADDR_WIDTH-1:0] im_address,
  output logic                  im_cs,
  output logic                  im_oe,
  output logic                  im_we,
  input  logic [DATA_WIDTH-1:0] im_data,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  input  logic                  instr_ready,
  output logic                  busy
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [CntW-1:0]       count_q;
  logic [PtrW-1:0]       rd_ptr_q;
  logic [PtrW-1:0]       wr_ptr_q;
  logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];

  logic issue;
  logic pop;
  logic flush;
  logic stop_run;
  logic push;

  always_comb begin
    issue       = (state_q == StRun) && (count_q < DepthCnt);
    im_cs       = issue;
    im_oe       = issue;
    im_we       = 1'b0;
    im_address  = pc_q;
    instr_valid = (count_q != '0);
    instr_data  = instr_valid ? fifo_data_q[rd_ptr_q] : '0;
    instr_addr  = instr_valid ? fifo_addr_q[rd_ptr_q] : '0;
    busy        = (state_q == StRun) || instr_valid;
    pop         = instr_valid && instr_ready;
    // start always restarts; redirect only matters while running
    flush       = start || (redirect_valid && (state_q == StRun));
    stop_run    = stop && (state_q == StRun);
    push        = issue && !stop_run;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else if (flush) begin
      // word on im_data this cycle belongs to the old stream and is dropped
      state_q  <= StRun;
      pc_q     <= start ? start_addr : redirect_addr;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (stop_run) begin
        state_q <= StIdle;
      end
      if (push) begin
        fifo_addr_q[wr_ptr_q] <= pc_q;
        fifo_data_q[wr_ptr_q] <= im_data;
        wr_ptr_q              <= wr_ptr_q + PtrW'(1);
        pc_q                  <= pc_q + ADDR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Randomised + directed bench for imem_fetch_ctrl; a queue-level fetch model feeds a
// scoreboard that the negedge monitor checks against every DUT output.
module tb_imem_fetch_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 6;
  localparam int unsigned FD = 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_addr;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic          stop;
  logic [AW-1:0] im_address;
  logic          im_cs;
  logic          im_oe;
  logic          im_we;
  logic [DW-1:0] im_data;
  logic          instr_valid;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_addr;
  logic          instr_ready;
  logic          busy;

  logic [DW-1:0] ram [2**AW];
  assign im_data = ram[im_address];

  imem_fetch_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .start_addr    (start_addr),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .stop          (stop),
    .im_address    (im_address),
    .im_cs         (im_cs),
    .im_oe         (im_oe),
    .im_we         (im_we),
    .im_data       (im_data),
    .instr_valid   (instr_valid),
    .instr_data    (instr_data),
    .instr_addr    (instr_addr),
    .instr_ready   (instr_ready),
    .busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  // Reference model: running flag, fetch pointer and the queue of words waiting for
  // the decoder. The queue doubles as the scoreboard of expected deliveries.
  bit            m_run;
  logic [AW-1:0] m_pc;
  ent_t          m_q[$];

  int vectors;
  int errs;

  initial begin
    m_run = 1'b0;
    m_pc  = '0;
    vectors = 0;
    errs    = 0;
  end

  always @(posedge clk) begin
    bit   can_issue;
    bit   take;
    ent_t e;
    if (reset) begin
      m_run = 1'b0;
      m_pc  = '0;
      m_q.delete();
    end else if (start) begin
      m_run = 1'b1;
      m_pc  = start_addr;
      m_q.delete();
    end else if (redirect_valid && m_run) begin
      m_pc = redirect_addr;
      m_q.delete();
    end else begin
      can_issue = m_run && (m_q.size() < FD);
      take      = (m_q.size() > 0) && instr_ready;
      if (stop && m_run) begin
        m_run     = 1'b0;
        can_issue = 1'b0;
      end
      if (take) void'(m_q.pop_front());
      if (can_issue) begin
        e.a = m_pc;
        e.d = ram[m_pc];
        m_q.push_back(e);
        m_pc = m_pc + 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output checked mid-cycle against the model.
  always @(negedge clk) begin
    logic exp_cs;
    exp_cs = m_run && (m_q.size() < FD);
    chk("im_cs", 64'(im_cs), 64'(exp_cs));
    chk("im_oe", 64'(im_oe), 64'(exp_cs));
    chk("im_we", 64'(im_we), 64'(0));
    chk("im_address", 64'(im_address), 64'(m_pc));
    chk("instr_valid", 64'(instr_valid), 64'(m_q.size() > 0));
    chk("busy", 64'(busy), 64'(m_run || (m_q.size() > 0)));
    if (m_q.size() > 0) begin
      chk(instr_ready ? "deliver_addr" : "head_addr", 64'(instr_addr), 64'(m_q[0].a));
      chk(instr_ready ? "deliver_data" : "head_data", 64'(instr_data), 64'(m_q[0].d));
    end else begin
      chk("idle_addr", 64'(instr_addr), 64'(0));
      chk("idle_data", 64'(instr_data), 64'(0));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    reset          = 1'b0;
    start          = 1'b0;
    redirect_valid = 1'b0;
    stop           = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    for (int k = 0; k < 2**AW; k++) ram[k] = DW'(k + 32'h100);
    reset          = 1'b1;
    start          = 1'b0;
    start_addr     = '0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    stop           = 1'b0;
    instr_ready    = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc();
    cycles(2);

    // Streaming from 5 with decoder always ready
    instr_ready = 1'b1; start = 1'b1; start_addr = 6'd5; cyc();
    cycles(8);
    // Address wrap at top of RAM
    start = 1'b1; start_addr = 6'd62; cyc();
    cycles(6);
    // Backpressure fills the FIFO, then drains in order
    instr_ready = 1'b0; start = 1'b1; start_addr = 6'd0; cyc();
    cycles(8);
    instr_ready = 1'b1;
    cycles(10);
    // Redirect with three buffered words
    instr_ready = 1'b0; start = 1'b1; start_addr = 6'd30; cyc();
    cycles(3);
    redirect_valid = 1'b1; redirect_addr = 6'd20; cyc();
    instr_ready = 1'b1;
    cycles(6);
    // Stop with two buffered words, drain, then redirect while idle
    instr_ready = 1'b0; start = 1'b1; start_addr = 6'd10; cyc();
    cycles(2);
    stop = 1'b1; cyc();
    cycles(2);
    instr_ready = 1'b1;
    cycles(4);
    redirect_valid = 1'b1; redirect_addr = 6'd7; cyc();
    cycles(3);
    // Reset with a full FIFO, then restart
    instr_ready = 1'b0; start = 1'b1; start_addr = 6'd40; cyc();
    cycles(6);
    reset = 1'b1; cyc();
    cycles(2);
    instr_ready = 1'b1; start = 1'b1; start_addr = 6'd3; cyc();
    cycles(5);

    // Random control traffic, including coincident start/redirect/stop
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 299) == 0);
      start          = ($urandom_range(0, 39) == 0);
      start_addr     = AW'($urandom);
      redirect_valid = ($urandom_range(0, 14) == 0);
      redirect_addr  = AW'($urandom);
      stop           = ($urandom_range(0, 29) == 0);
      instr_ready    = ($urandom_range(0, 9) < 6);
      cyc();
    end
    cycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
